// File: rtl/game_pkg.sv
// Shared types and constants for the penalty shoot-out sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    PLAY,
    SHOW,
    EVAL,
    DONE
  } seq_state_t;

  localparam logic ROLE_SHOOT = 1'b0;
  localparam logic ROLE_KEEP  = 1'b1;

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned TIMER_W = 32;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  // Increment that sticks at the counter ceiling instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/delay_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module delay_timer
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               en_i,
  output logic               expired_o
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic               expired_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end
  end

  // Expired flag is registered from the next count so it tracks cnt_q exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == '0);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/round_sequencer.sv
// Solo-mode penalty shoot-out sequencer: alternates SHOOT/KEEP turns, scores
// results and decides regulation finish, sudden death or a capped draw.
module round_sequencer
  import game_pkg::*;
#(
  parameter int unsigned        ROUNDS_REGULAR = 5,
  parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 32'd195_000_000,
  parameter logic [TIMER_W-1:0] RESULT_HOLD    = 32'd65_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               turn_done,
  input  logic               turn_scored,
  output logic               turn_role,
  output logic               turn_start,
  output logic [SCORE_W-1:0] round_idx,
  output logic [SCORE_W-1:0] score_player,
  output logic [SCORE_W-1:0] score_enemy,
  output logic               timeout_flag,
  output logic               busy,
  output logic               match_end,
  output logic               match_result,
  output logic               match_draw
);

  seq_state_t         state_q, state_d;
  logic               role_q, role_d;
  logic               turn_start_q, turn_start_d;
  logic [SCORE_W-1:0] round_q, round_d;
  logic [SCORE_W-1:0] sp_q, sp_d, se_q, se_d;
  logic [SCORE_W-1:0] kp_q, kp_d, ke_q, ke_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;
  logic               end_q, end_d;
  logic               result_q, result_d;
  logic               draw_q, draw_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_expired;
  logic               goal;

  delay_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       ((state_q == PLAY) || (state_q == SHOW)),
    .expired_o  (tmr_expired)
  );

  // Match-end decisions in 5-bit unsigned so "score + kicks left" cannot wrap.
  logic [SCORE_W:0] sp5, se5, kp5, ke5, n5;
  logic             regular, reg_end, sd_end, cap_draw;

  assign sp5      = {1'b0, sp_q};
  assign se5      = {1'b0, se_q};
  assign kp5      = {1'b0, kp_q};
  assign ke5      = {1'b0, ke_q};
  assign n5       = (SCORE_W+1)'(ROUNDS_REGULAR);
  assign regular  = (kp5 <= n5) && (ke5 <= n5);
  assign reg_end  = regular && ((sp5 > se5 + (n5 - ke5)) || (se5 > sp5 + (n5 - kp5)));
  assign sd_end   = (kp5 >= n5) && (ke5 >= n5) && (kp_q == ke_q) && (sp_q != se_q);
  assign cap_draw = (kp_q == SCORE_MAX) && (ke_q == SCORE_MAX) && (sp_q == se_q);

  always_comb begin
    state_d      = state_q;
    role_d       = role_q;
    turn_start_d = 1'b0;
    round_d      = round_q;
    sp_d         = sp_q;
    se_d         = se_q;
    kp_d         = kp_q;
    ke_d         = ke_q;
    timeout_d    = 1'b0;
    result_d     = result_q;
    draw_d       = draw_q;
    tmr_load     = 1'b0;
    tmr_val      = RESULT_HOLD - TIMER_W'(1);
    goal         = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = ARM;
          role_d   = ROLE_SHOOT;
          round_d  = '0;
          sp_d     = '0;
          se_d     = '0;
          kp_d     = '0;
          ke_d     = '0;
          result_d = 1'b0;
          draw_d   = 1'b0;
        end
      end
      ARM: begin
        turn_start_d = 1'b1;
        tmr_load     = 1'b1;
        tmr_val      = TIMEOUT_CYCLES - TIMER_W'(1);
        state_d      = PLAY;
      end
      PLAY: begin
        // A turn_done on the expiry cycle wins over the timeout.
        if (turn_done || tmr_expired) begin
          goal      = turn_done ? turn_scored : (role_q == ROLE_KEEP);
          timeout_d = !turn_done;
          if (role_q == ROLE_SHOOT) begin
            kp_d = sat_inc(kp_q);
            if (goal) sp_d = sat_inc(sp_q);
          end else begin
            ke_d = sat_inc(ke_q);
            if (goal) se_d = sat_inc(se_q);
          end
          tmr_load = 1'b1;
          state_d  = SHOW;
        end
      end
      SHOW: begin
        if (tmr_expired) state_d = EVAL;
      end
      EVAL: begin
        if (reg_end || sd_end || cap_draw) begin
          state_d  = DONE;
          result_d = (sp_q > se_q);
          draw_d   = cap_draw;
        end else begin
          role_d  = ~role_q;
          if (role_q == ROLE_KEEP) round_d = sat_inc(round_q);
          state_d = ARM;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d      = IDLE;
      role_d       = ROLE_SHOOT;
      turn_start_d = 1'b0;
      round_d      = '0;
      sp_d         = '0;
      se_d         = '0;
      kp_d         = '0;
      ke_d         = '0;
      timeout_d    = 1'b0;
      result_d     = 1'b0;
      draw_d       = 1'b0;
      tmr_load     = 1'b0;
    end

    busy_d = (state_d == ARM) || (state_d == PLAY) || (state_d == SHOW) || (state_d == EVAL);
    end_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      role_q       <= ROLE_SHOOT;
      turn_start_q <= 1'b0;
      round_q      <= '0;
      sp_q         <= '0;
      se_q         <= '0;
      kp_q         <= '0;
      ke_q         <= '0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
      end_q        <= 1'b0;
      result_q     <= 1'b0;
      draw_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      role_q       <= role_d;
      turn_start_q <= turn_start_d;
      round_q      <= round_d;
      sp_q         <= sp_d;
      se_q         <= se_d;
      kp_q         <= kp_d;
      ke_q         <= ke_d;
      timeout_q    <= timeout_d;
      busy_q       <= busy_d;
      end_q        <= end_d;
      result_q     <= result_d;
      draw_q       <= draw_d;
    end
  end

  assign turn_role    = role_q;
  assign turn_start   = turn_start_q;
  assign round_idx    = round_q;
  assign score_player = sp_q;
  assign score_enemy  = se_q;
  assign timeout_flag = timeout_q;
  assign busy         = busy_q;
  assign match_end    = end_q;
  assign match_result = result_q;
  assign match_draw   = draw_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with a 20-cycle turn timeout and 4-cycle result hold.
module tb_round_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, abort, turn_done, turn_scored;
  logic       turn_role, turn_start, timeout_flag, busy;
  logic       match_end, match_result, match_draw;
  logic [3:0] round_idx, score_player, score_enemy;

  int n_checks = 0;
  int n_fail   = 0;

  round_sequencer #(
    .ROUNDS_REGULAR (5),
    .TIMEOUT_CYCLES (32'd20),
    .RESULT_HOLD    (32'd4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .turn_done    (turn_done),
    .turn_scored  (turn_scored),
    .turn_role    (turn_role),
    .turn_start   (turn_start),
    .round_idx    (round_idx),
    .score_player (score_player),
    .score_enemy  (score_enemy),
    .timeout_flag (timeout_flag),
    .busy         (busy),
    .match_end    (match_end),
    .match_result (match_result),
    .match_draw   (match_draw)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Waits on negedges for turn_start; k is the number of negedges waited, -1 on timeout.
  task automatic wait_ts(input int max_cyc, output int k);
    k = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (turn_start === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wait_end(input int max_cyc, output int k);
    k = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (match_end === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wait_timeout(input int max_cyc, output int k);
    k = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (timeout_flag === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  // Waits for the turn to arm, then resolves it immediately; returns one cycle later.
  task automatic play_turn(input logic scored, output int k);
    wait_ts(60, k);
    if (k > 0) begin
      turn_done   = 1'b1;
      turn_scored = scored;
      @(negedge clk);
      turn_done   = 1'b0;
      turn_scored = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; turn_done = 1'b0; turn_scored = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({turn_role, turn_start, round_idx, score_player, score_enemy, timeout_flag,
         busy, match_end, match_result, match_draw} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required all zero",
               {turn_role, turn_start, round_idx, score_player, score_enemy, timeout_flag,
                busy, match_end, match_result, match_draw});
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({busy, turn_start} !== 2'b10) begin
      n_fail++;
      $display("FAIL arm_cycle: busy,turn_start=%b required 10", {busy, turn_start});
    end
    @(negedge clk);
    n_checks++;
    if ({turn_start, turn_role, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL start_latency: turn_start,role,busy=%b required 101",
               {turn_start, turn_role, busy});
    end
    @(negedge clk);
    n_checks++;
    if (turn_start !== 1'b0) begin
      n_fail++;
      $display("FAIL turn_start_pulse: got %b required 0", turn_start);
    end
  endtask

  task automatic test_early_finish();
    int k;
    pulse_abort();
    pulse_start();
    for (int t = 0; t < 6; t++) begin
      play_turn((t % 2) == 0, k);
      n_checks++;
      if (k <= 0) begin
        n_fail++;
        $display("FAIL early_turn%0d_armed: waited %0d required >0", t, k);
      end
      if (t == 0) begin
        n_checks++;
        if (score_player !== 4'd1) begin
          n_fail++;
          $display("FAIL score_latency: score_player=%0d required 1", score_player);
        end
      end
    end
    wait_end(20, k);
    n_checks++;
    if (k !== 5) begin
      n_fail++;
      $display("FAIL early_end_latency: cycles=%0d required 5", k);
    end
    n_checks++;
    if ({match_end, match_result, match_draw, busy} !== 4'b1100) begin
      n_fail++;
      $display("FAIL early_end_flags: end,result,draw,busy=%b required 1100",
               {match_end, match_result, match_draw, busy});
    end
    n_checks++;
    if ({round_idx, score_player, score_enemy} !== {4'd2, 4'd3, 4'd0}) begin
      n_fail++;
      $display("FAIL early_end_counts: round=%0d sp=%0d se=%0d required 2 3 0",
               round_idx, score_player, score_enemy);
    end
  endtask

  task automatic test_sudden_death();
    int k;
    pulse_start();
    n_checks++;
    if ({match_end, score_player, score_enemy} !== 9'd0) begin
      n_fail++;
      $display("FAIL restart_clear: end=%b sp=%0d se=%0d required 0 0 0",
               match_end, score_player, score_enemy);
    end
    for (int t = 0; t < 10; t++) begin
      play_turn(1'b1, k);
      if (t == 1) begin
        n_checks++;
        if (k !== 6) begin
          n_fail++;
          $display("FAIL show_to_turn_start: cycles=%0d required 6", k);
        end
      end
    end
    n_checks++;
    if ({match_end, score_player, score_enemy} !== {1'b0, 4'd5, 4'd5}) begin
      n_fail++;
      $display("FAIL regulation_tie: end=%b sp=%0d se=%0d required 0 5 5",
               match_end, score_player, score_enemy);
    end
    play_turn(1'b1, k);
    n_checks++;
    if ({match_end, round_idx, turn_role} !== {1'b0, 4'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL sd_shoot: end=%b round=%0d role=%b required 0 5 0",
               match_end, round_idx, turn_role);
    end
    play_turn(1'b0, k);
    wait_end(20, k);
    n_checks++;
    if ({match_end, match_result, match_draw} !== 3'b110) begin
      n_fail++;
      $display("FAIL sd_end_flags: end,result,draw=%b required 110",
               {match_end, match_result, match_draw});
    end
    n_checks++;
    if ({round_idx, score_player, score_enemy} !== {4'd5, 4'd6, 4'd5}) begin
      n_fail++;
      $display("FAIL sd_end_counts: round=%0d sp=%0d se=%0d required 5 6 5",
               round_idx, score_player, score_enemy);
    end
  endtask

  task automatic test_timeout();
    int k;
    pulse_abort();
    pulse_start();
    wait_ts(10, k);
    wait_timeout(40, k);
    n_checks++;
    if (k !== 20) begin
      n_fail++;
      $display("FAIL shoot_timeout_cycle: cycles=%0d required 20", k);
    end
    n_checks++;
    if ({score_player, score_enemy} !== 8'd0) begin
      n_fail++;
      $display("FAIL shoot_timeout_miss: sp=%0d se=%0d required 0 0", score_player, score_enemy);
    end
    // Late turn_done and start during SHOW must both be ignored.
    turn_done = 1'b1; turn_scored = 1'b1; start = 1'b1;
    @(negedge clk);
    turn_done = 1'b0; turn_scored = 1'b0; start = 1'b0;
    n_checks++;
    if ({timeout_flag, score_player} !== 5'd0) begin
      n_fail++;
      $display("FAIL show_ignores_done: flag=%b sp=%0d required 0 0", timeout_flag, score_player);
    end
    wait_ts(20, k);
    n_checks++;
    if ({k > 0, turn_role, round_idx} !== {1'b1, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL keep_turn_armed: waited=%0d role=%b round=%0d required >0 1 0",
               k, turn_role, round_idx);
    end
    wait_timeout(40, k);
    n_checks++;
    if ({k == 20, score_player, score_enemy} !== {1'b1, 4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL keep_timeout_goal: cycles=%0d sp=%0d se=%0d required 20 0 1",
               k, score_player, score_enemy);
    end
  endtask

  task automatic test_abort();
    int k;
    pulse_abort();
    pulse_start();
    play_turn(1'b1, k);
    wait_ts(20, k);
    n_checks++;
    if ({k > 0, score_player} !== {1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL abort_setup: waited=%0d sp=%0d required >0 1", k, score_player);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    turn_done = 1'b1; turn_scored = 1'b1;
    n_checks++;
    if ({busy, score_player} !== 5'd0) begin
      n_fail++;
      $display("FAIL abort_clear: busy=%b sp=%0d required 0 0", busy, score_player);
    end
    @(negedge clk);
    turn_done = 1'b0; turn_scored = 1'b0;
    n_checks++;
    if ({busy, score_player, score_enemy, round_idx, turn_role} !== 14'd0) begin
      n_fail++;
      $display("FAIL abort_drop_done: busy=%b sp=%0d se=%0d round=%0d role=%b required all 0",
               busy, score_player, score_enemy, round_idx, turn_role);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, turn_start, match_end} !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_stays_idle: busy,turn_start,end=%b required 000",
               {busy, turn_start, match_end});
    end
  endtask

  task automatic test_expiry_tie();
    int k;
    pulse_start();
    wait_ts(10, k);
    repeat (19) @(negedge clk);
    turn_done = 1'b1; turn_scored = 1'b1;
    @(negedge clk);
    turn_done = 1'b0; turn_scored = 1'b0;
    n_checks++;
    if ({score_player, timeout_flag} !== {4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL expiry_tie_done_wins: sp=%0d flag=%b required 1 0", score_player, timeout_flag);
    end
    @(negedge clk);
    n_checks++;
    if (timeout_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL expiry_tie_no_flag: flag=%b required 0", timeout_flag);
    end
  endtask

  initial begin
    test_reset();
    test_early_finish();
    test_sudden_death();
    test_timeout();
    test_abort();
    test_expiry_tie();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
